// File: rtl/unimem.sv
// Unibus slave block RAM for the PDP-11/34: answers DATI/DATIP/DATO/DATOB
// cycles on port A while the ARM can configure the window and peek/poke on port B.
module unimem #(
  parameter int AW     = 15,
  parameter int DESKEW = 15
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  input  logic        msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  typedef enum logic [2:0] {IDLE, DSKW, MISS, ACC, RD2, HOLD} state_t;

  localparam int CW = $clog2(DESKEW + 1);
  localparam logic [CW-1:0] TERM = CW'(DESKEW - 1);

  state_t         state;
  logic [CW-1:0]  counter;
  logic           rd_cyc;
  logic [11:0]    cycount;

  logic           enable;
  logic [17:AW+1] base_hi;
  logic [17:1]    armaddr_w;
  logic [15:0]    armdata;
  logic           rd_pend1, rd_pend2;

  logic [15:0]    mem [0:(2**AW)-1];
  logic [15:0]    ram_a_q, ram_b_q;

  logic hit, a_we, a_we_hi, a_we_lo, b_we;
  logic unused_wdata;

  assign unused_wdata = ^armwdata[30:18];

  // The top 8KB of the address space is the I/O page and is never claimed.
  assign hit     = enable && (a_in_h[17:AW+1] == base_hi) && (a_in_h[17:13] != 5'b11111);
  assign a_we    = (state == ACC) && msyn_in_h && c_in_h[1] && !init_in_h;
  assign a_we_hi = a_we && (!c_in_h[0] || a_in_h[0]);
  assign a_we_lo = a_we && (!c_in_h[0] || !a_in_h[0]);
  assign b_we    = armwrite && (armwaddr == 2'd3);

  // Unibus writes are placed after the ARM write so they win on a collision.
  always_ff @(posedge CLOCK) begin
    ram_a_q <= mem[a_in_h[AW:1]];
    ram_b_q <= mem[armaddr_w[AW:1]];
    if (b_we)
      mem[armaddr_w[AW:1]] <= armwdata[15:0];
    if (a_we_hi)
      mem[a_in_h[AW:1]][15:8] <= d_in_h[15:8];
    if (a_we_lo)
      mem[a_in_h[AW:1]][7:0] <= d_in_h[7:0];
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      counter    <= '0;
      rd_cyc     <= 1'b0;
      cycount    <= '0;
      d_out_h    <= '0;
      ssyn_out_h <= 1'b0;
    end else if (init_in_h) begin
      state      <= IDLE;
      d_out_h    <= '0;
      ssyn_out_h <= 1'b0;
    end else begin
      case (state)
        IDLE: if (msyn_in_h && !ssyn_out_h) begin
          counter <= '0;
          state   <= DSKW;
        end
        DSKW: begin
          if (!msyn_in_h)
            state <= IDLE;
          else if (counter == TERM)
            state <= hit ? ACC : MISS;
          else
            counter <= counter + CW'(1);
        end
        MISS: if (!msyn_in_h) state <= IDLE;
        ACC: begin
          if (!msyn_in_h) begin
            state <= IDLE;
          end else begin
            rd_cyc <= !c_in_h[1];
            state  <= RD2;
          end
        end
        RD2: begin
          if (rd_cyc)
            d_out_h <= ram_a_q;
          ssyn_out_h <= 1'b1;
          cycount    <= cycount + 12'd1;
          state      <= HOLD;
        end
        HOLD: if (!msyn_in_h) begin
          d_out_h    <= '0;
          ssyn_out_h <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reg 2 write schedules a port-B read that lands in armdata two cycles later.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      enable    <= 1'b0;
      base_hi   <= '0;
      armaddr_w <= '0;
      armdata   <= '0;
      rd_pend1  <= 1'b0;
      rd_pend2  <= 1'b0;
    end else begin
      rd_pend1 <= armwrite && (armwaddr == 2'd2);
      rd_pend2 <= rd_pend1;
      if (rd_pend2)
        armdata <= ram_b_q;
      if (armwrite) begin
        case (armwaddr)
          2'd1: begin
            enable  <= armwdata[31];
            base_hi <= armwdata[17:AW+1];
          end
          2'd2: armaddr_w <= armwdata[17:1];
          2'd3: begin
            armaddr_w <= armaddr_w + 17'd1;
            armdata   <= armwdata[15:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    armrdata = '0;
    case (armraddr)
      2'd0: armrdata = 32'h554D1001;
      2'd1: armrdata = {enable, 1'b0, cycount, base_hi, {(AW+1){1'b0}}};
      2'd2: armrdata = {14'b0, armaddr_w, 1'b0};
      2'd3: armrdata = {16'b0, armdata};
      default: armrdata = '0;
    endcase
  end

endmodule

// File: tb/tb_unimem.sv
// Directed bench for unimem: ARM register access, Unibus read/write cycles,
// window misses, aborts, INIT and asynchronous reset.
module tb_unimem;

  localparam int AW     = 15;
  localparam int DESKEW = 15;
  localparam int LAT    = DESKEW + 3;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = 32'd0;
  logic [31:0] armrdata;
  logic [17:0] a_in_h = 18'd0;
  logic [1:0]  c_in_h = 2'd0;
  logic [15:0] d_in_h = 16'd0;
  logic        init_in_h = 1'b0;
  logic        msyn_in_h = 1'b0;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK = ~CLOCK;

  unimem #(.AW(AW), .DESKEW(DESKEW)) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .armwrite   (armwrite),
    .armraddr   (armraddr),
    .armwaddr   (armwaddr),
    .armwdata   (armwdata),
    .armrdata   (armrdata),
    .a_in_h     (a_in_h),
    .c_in_h     (c_in_h),
    .d_in_h     (d_in_h),
    .init_in_h  (init_in_h),
    .msyn_in_h  (msyn_in_h),
    .d_out_h    (d_out_h),
    .ssyn_out_h (ssyn_out_h)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic armWrite(input logic [1:0] r, input logic [31:0] v);
    @(negedge CLOCK);
    armwrite = 1'b1;
    armwaddr = r;
    armwdata = v;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic armRead(input logic [1:0] r, output logic [31:0] v);
    armraddr = r;
    #1;
    v = armrdata;
  endtask

  // Point armaddr at a byte address and fetch the word through port B.
  task automatic peek(input logic [17:0] byte_addr, output logic [31:0] v);
    armWrite(2'd2, {14'd0, byte_addr});
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    armRead(2'd3, v);
  endtask

  task automatic startCycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                            output int lat);
    @(negedge CLOCK);
    a_in_h    = a;
    c_in_h    = c;
    d_in_h    = d;
    msyn_in_h = 1'b1;
    lat = 0;
    for (int i = 1; i <= LAT + 20; i++) begin
      @(posedge CLOCK);
      #1;
      if (ssyn_out_h) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic endCycle();
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [17:0] a, input logic [1:0] c,
                               input logic [15:0] d, input logic [15:0] exp_dout);
    int lat;
    startCycle(a, c, d, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(LAT));
    checkOutput({tag, " dout"}, {16'd0, d_out_h}, {16'd0, exp_dout});
    @(posedge CLOCK);
    #1;
    checkOutput({tag, " hold"}, {15'd0, ssyn_out_h, d_out_h}, {15'd0, 1'b1, exp_dout});
    endCycle();
    checkOutput({tag, " release"}, {15'd0, ssyn_out_h, d_out_h}, 32'd0);
  endtask

  task automatic applyMiss(input string tag, input logic [17:0] a);
    logic seen;
    seen = 1'b0;
    @(negedge CLOCK);
    a_in_h    = a;
    c_in_h    = 2'b00;
    msyn_in_h = 1'b1;
    repeat (1000) begin
      @(posedge CLOCK);
      #1;
      if (ssyn_out_h || d_out_h != 16'd0) seen = 1'b1;
    end
    checkOutput(tag, {31'd0, seen}, 32'd0);
    endCycle();
  endtask

  // Drop MSYN after n posedges of a DATO, which lands in DSKW or ACC.
  task automatic abortCycle(input string tag, input int n, input logic [15:0] d);
    logic seen;
    seen = 1'b0;
    @(negedge CLOCK);
    a_in_h    = 18'o000400;
    c_in_h    = 2'b10;
    d_in_h    = d;
    msyn_in_h = 1'b1;
    repeat (n) @(posedge CLOCK);
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    repeat (LAT + 4) begin
      @(posedge CLOCK);
      #1;
      if (ssyn_out_h) seen = 1'b1;
    end
    checkOutput({tag, " ssyn"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int lat;

    #2;
    checkOutput("reset outputs", {15'd0, ssyn_out_h, d_out_h}, 32'd0);
    armRead(2'd0, v);
    checkOutput("reset reg0", v, 32'h554D1001);
    armRead(2'd1, v);
    checkOutput("reset reg1", v, 32'h00000000);
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    armWrite(2'd1, 32'h80000000);
    armRead(2'd1, v);
    checkOutput("reg1 enable", v, 32'h80000000);
    armWrite(2'd2, 32'h00000100);
    armWrite(2'd3, 32'h0000A72E);
    armRead(2'd2, v);
    checkOutput("reg2 increment", v, 32'h00000102);
    armWrite(2'd3, 32'h00001234);
    armRead(2'd2, v);
    checkOutput("reg2 second increment", v, 32'h00000104);
    armRead(2'd3, v);
    checkOutput("reg3 after write", v, 32'h00001234);
    peek(18'h00100, v);
    checkOutput("reg3 readback", v, 32'h0000A72E);
    $display("[TB] ARM register phase done");

    applyStimulus("DATI 400", 18'o000400, 2'b00, 16'h0000, 16'hA72E);
    armRead(2'd1, v);
    checkOutput("cycount 1", v, 32'h80040000);

    applyStimulus("DATOB 401", 18'o000401, 2'b11, 16'hFF00, 16'h0000);
    peek(18'h00100, v);
    checkOutput("DATOB high byte", v, 32'h0000FF2E);
    applyStimulus("DATOB 400", 18'o000400, 2'b11, 16'h00FF, 16'h0000);
    peek(18'h00100, v);
    checkOutput("DATOB low byte", v, 32'h0000FFFF);
    applyStimulus("DATO 400", 18'o000400, 2'b10, 16'h5A5A, 16'h0000);
    peek(18'h00100, v);
    checkOutput("DATO word", v, 32'h00005A5A);
    applyStimulus("DATI 400 again", 18'o000400, 2'b00, 16'h0000, 16'h5A5A);
    armRead(2'd1, v);
    checkOutput("cycount 5", v, 32'h80140000);
    $display("[TB] Unibus access phase done");

    applyMiss("miss beyond window", 18'o200000);
    armWrite(2'd1, 32'h80030000);
    armRead(2'd1, v);
    checkOutput("reg1 base 3", v, 32'h80170000);
    applyMiss("miss io page", 18'o777570);
    armWrite(2'd1, 32'h00000000);
    applyMiss("miss disabled", 18'o000400);
    armWrite(2'd1, 32'h80000000);

    abortCycle("abort dskw", 5, 16'h1111);
    abortCycle("abort acc", DESKEW + 1, 16'h2222);
    peek(18'h00100, v);
    checkOutput("abort no write", v, 32'h00005A5A);
    $display("[TB] miss and abort phase done");

    startCycle(18'o000400, 2'b00, 16'h0000, lat);
    checkOutput("init pre latency", 32'(lat), 32'(LAT));
    checkOutput("init pre dout", {16'd0, d_out_h}, 32'h00005A5A);
    @(negedge CLOCK);
    init_in_h = 1'b1;
    @(posedge CLOCK);
    #1;
    checkOutput("init clears", {15'd0, ssyn_out_h, d_out_h}, 32'd0);
    @(negedge CLOCK);
    init_in_h = 1'b0;
    msyn_in_h = 1'b0;
    applyStimulus("DATI after init", 18'o000400, 2'b00, 16'h0000, 16'h5A5A);
    armRead(2'd1, v);
    checkOutput("cycount 7", v, 32'h801C0000);

    startCycle(18'o000400, 2'b00, 16'h0000, lat);
    checkOutput("reset pre latency", 32'(lat), 32'(LAT));
    @(negedge CLOCK);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async reset outputs", {15'd0, ssyn_out_h, d_out_h}, 32'd0);
    armRead(2'd1, v);
    checkOutput("async reset reg1", v, 32'h00000000);
    armRead(2'd0, v);
    checkOutput("async reset reg0", v, 32'h554D1001);
    msyn_in_h = 1'b0;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;
    checkOutput("post reset idle", {15'd0, ssyn_out_h, d_out_h}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
